// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: single-outstanding imem
// handshake, one-entry stall buffer, and squash of stale responses after redirect/reset.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          IMEM_AW   = 10,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        instr,
   output logic [31:0]        pc_out,
   output logic [31:0]        pc_plus_4_out,
   output logic               if_id_valid
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [31:0] fetch_pc, fetch_pc_nx;
   logic [31:0] req_pc, req_pc_nx;
   logic [31:0] buf_instr, buf_instr_nx;
   logic [31:0] buf_pc, buf_pc_nx;
   logic [1:0]  drop_cnt, drop_nx;
   logic        live, live_nx;
   logic        accept, stale_rsp, live_rsp, squash, kill_live;

   // drop_cnt counts responses still owed for requests that were orphaned by a
   // redirect or reset; live marks that the newest outstanding request is wanted.
   assign imem_req  = (state == ST_FETCH) && reset;
   assign imem_addr = fetch_pc[IMEM_AW+1:2];
   assign accept    = imem_req && imem_ready;
   assign stale_rsp = imem_rvalid && (drop_cnt != 2'd0);
   assign live_rsp  = imem_rvalid && (drop_cnt == 2'd0) && live && (state == ST_WAIT);
   assign squash    = flush || redirect;
   assign kill_live = redirect && (((state == ST_FETCH) && accept) ||
                                   ((state == ST_WAIT) && live && !live_rsp));
   assign drop_nx   = drop_cnt - {1'b0, stale_rsp} + {1'b0, kill_live};
   assign req_pc_nx = accept ? fetch_pc : req_pc;

   // Next-state, fetch PC and hold-buffer logic
   always_comb begin
      state_nx     = state;
      fetch_pc_nx  = fetch_pc;
      live_nx      = live;
      buf_instr_nx = buf_instr;
      buf_pc_nx    = buf_pc;

      if (redirect) begin
         fetch_pc_nx = redirect_pc & ~32'd3;
         live_nx     = 1'b0;
      end else if (accept) begin
         fetch_pc_nx = fetch_pc + 32'd4;
         live_nx     = 1'b1;
      end else if (live_rsp) begin
         live_nx = 1'b0;
      end else begin
         live_nx = live;
      end

      case (state)
         ST_FETCH: begin
            if (accept) state_nx = ST_WAIT;
            else        state_nx = ST_FETCH;
         end
         ST_WAIT: begin
            if (live_rsp && stall && !squash) begin
               state_nx     = ST_HOLD;
               buf_instr_nx = imem_rdata;
               buf_pc_nx    = req_pc;
            end else if (live_rsp || (stale_rsp && !live)) begin
               state_nx = ST_FETCH;
            end else begin
               state_nx = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (squash || !stall) state_nx = ST_FETCH;
            else                  state_nx = ST_HOLD;
         end
         default: state_nx = ST_FETCH;
      endcase
   end

   // Fetch-side state registers; a reset turns every wanted request into a stale one
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_FETCH;
         fetch_pc  <= RESET_PC;
         req_pc    <= 32'd0;
         live      <= 1'b0;
         drop_cnt  <= drop_cnt + {1'b0, live}
                      - {1'b0, imem_rvalid && (live || (drop_cnt != 2'd0))};
         buf_instr <= 32'd0;
         buf_pc    <= 32'd0;
      end else begin
         state     <= state_nx;
         fetch_pc  <= fetch_pc_nx;
         req_pc    <= req_pc_nx;
         live      <= live_nx;
         drop_cnt  <= drop_nx;
         buf_instr <= buf_instr_nx;
         buf_pc    <= buf_pc_nx;
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (!reset) begin
         if_id_valid   <= 1'b0;
         instr         <= NOP_INSTR;
         pc_out        <= 32'd0;
         pc_plus_4_out <= 32'd0;
      end else if (squash) begin
         if_id_valid <= 1'b0;
         instr       <= NOP_INSTR;
      end else if (stall) begin
         if_id_valid   <= if_id_valid;
         instr         <= instr;
         pc_out        <= pc_out;
         pc_plus_4_out <= pc_plus_4_out;
      end else if (state == ST_HOLD) begin
         if_id_valid   <= 1'b1;
         instr         <= buf_instr;
         pc_out        <= buf_pc;
         pc_plus_4_out <= buf_pc + 32'd4;
      end else if (live_rsp) begin
         if_id_valid   <= 1'b1;
         instr         <= imem_rdata;
         pc_out        <= req_pc;
         pc_plus_4_out <= req_pc + 32'd4;
      end else begin
         if_id_valid <= 1'b0;
         instr       <= NOP_INSTR;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table on two instances (RESET_PC 0 and
// 0xFFFF_FFFC), then randomized traffic against a program-order reference model.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] D   = 32'h1000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, stl, fls, rdr, rdy, rv, req, vld;
   logic [1:0][31:0] rpc, rdat, ins, pco, pc4;
   logic [1:0][9:0]  addr;

   int checks   = 0;
   int failures = 0;

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
      .clk(clk), .reset(rst[0]), .stall(stl[0]), .flush(fls[0]), .redirect(rdr[0]),
      .redirect_pc(rpc[0]), .imem_req(req[0]), .imem_addr(addr[0]), .imem_ready(rdy[0]),
      .imem_rvalid(rv[0]), .imem_rdata(rdat[0]), .instr(ins[0]), .pc_out(pco[0]),
      .pc_plus_4_out(pc4[0]), .if_id_valid(vld[0]));

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .reset(rst[1]), .stall(stl[1]), .flush(fls[1]), .redirect(rdr[1]),
      .redirect_pc(rpc[1]), .imem_req(req[1]), .imem_addr(addr[1]), .imem_ready(rdy[1]),
      .imem_rvalid(rv[1]), .imem_rdata(rdat[1]), .instr(ins[1]), .pc_out(pco[1]),
      .pc_plus_4_out(pc4[1]), .if_id_valid(vld[1]));

   typedef struct {
      int          sel;
      logic        rst, stl, fls, rdr;
      logic [31:0] rpc;
      logic        rdy, rv;
      logic [31:0] rdat;
      logic        e_req;
      logic [9:0]  e_addr;
      logic        e_vld;
      logic [31:0] e_pc, e_ins;
   } vec_t;

   typedef struct {
      logic [9:0] a;
      int         due;
   } mreq_t;

   function automatic vec_t v(input int sel, input logic r, s, f, d, input logic [31:0] rp,
                              input logic y, w, input logic [31:0] rd, input logic eq,
                              input logic [9:0] ea, input logic ev, input logic [31:0] ep, ei);
      vec_t t;
      t.sel = sel; t.rst = r; t.stl = s; t.fls = f; t.rdr = d; t.rpc = rp;
      t.rdy = y; t.rv = w; t.rdat = rd; t.e_req = eq; t.e_addr = ea;
      t.e_vld = ev; t.e_pc = ep; t.e_ins = ei;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One cycle of a table vector: drive at negedge, check request before the edge,
   // check IF/ID after it. The non-selected instance is kept idle on the memory side.
   task automatic apply(input vec_t t);
      int s;
      s = t.sel;
      @(negedge clk);
      rv  = 2'b00;
      rdy = 2'b00;
      rst[s] = t.rst; stl[s] = t.stl; fls[s] = t.fls; rdr[s] = t.rdr; rpc[s] = t.rpc;
      rdy[s] = t.rdy; rv[s] = t.rv; rdat[s] = t.rdat;
      #1;
      chk("imem_req", 32'(req[s]), 32'(t.e_req));
      if (t.e_req) chk("imem_addr", 32'(addr[s]), 32'(t.e_addr));
      @(posedge clk);
      #1;
      chk("if_id_valid", 32'(vld[s]), 32'(t.e_vld));
      chk("instr", ins[s], t.e_ins);
      if (t.e_vld || !t.rst) begin
         chk("pc_out", pco[s], t.e_pc);
         chk("pc_plus_4_out", pc4[s], t.rst ? t.e_pc + 32'd4 : 32'd0);
      end
   endtask

   vec_t        tab[$];
   mreq_t       mq[$];
   logic [31:0] exp_pc, p_ins, p_pc, p_pc4, r_rpc;
   logic        p_vld, acc, r_rst, r_rdr, r_fls, r_stl;
   logic [9:0]  acc_a;
   int          cyc, idle, delivered;

   initial begin
      rst = '0; stl = '0; fls = '0; rdr = '0; rdy = '0; rv = '0;
      rpc = '0; rdat = '0;

      // instance 0: start-up, stall into HOLD, redirect in WAIT, flush+stall, ready low
      //                   r  s  f  d  rpc            y  v  rdata          req addr    v  pc            instr
      tab.push_back(v(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 10'h000, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h000, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 1, D + 32'd0,     0, 10'h000, 1, 32'h0,        D + 32'd0));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h001, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 1, D + 32'd1,     0, 10'h000, 1, 32'h4,        D + 32'd1));
      tab.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h002, 1, 32'h4,        D + 32'd1));
      tab.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 1, D + 32'd2,     0, 10'h000, 1, 32'h4,        D + 32'd1));
      tab.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 0, 32'h0,         0, 10'h000, 1, 32'h4,        D + 32'd1));
      tab.push_back(v(0, 1, 1, 0, 0, 32'h0,        1, 0, 32'h0,         0, 10'h000, 1, 32'h4,        D + 32'd1));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 10'h000, 1, 32'h8,        D + 32'd2));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h003, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 1, D + 32'd3,     0, 10'h000, 1, 32'hC,        D + 32'd3));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h004, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 1, 32'h102,      1, 0, 32'h0,         0, 10'h000, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 1, D + 32'd4,     0, 10'h000, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h040, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 1, D + 32'h40,    0, 10'h000, 1, 32'h100,      D + 32'h40));
      tab.push_back(v(0, 1, 1, 1, 0, 32'h0,        0, 0, 32'h0,         1, 10'h041, 0, 32'h0,        NOP));
      for (int k = 0; k < 4; k++)
         tab.push_back(v(0, 1, 0, 0, 0, 32'h0,     0, 0, 32'h0,         1, 10'h041, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h041, 0, 32'h0,        NOP));
      tab.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 1, D + 32'h41,    0, 10'h000, 1, 32'h104,      D + 32'h41));
      // instance 1: PC wrap, then reset while waiting with the stale response arriving late
      tab.push_back(v(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 10'h000, 0, 32'h0,        NOP));
      tab.push_back(v(1, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h3FF, 0, 32'h0,        NOP));
      tab.push_back(v(1, 1, 0, 0, 0, 32'h0,        1, 1, 32'hAAAA_0000, 0, 10'h000, 1, 32'hFFFF_FFFC, 32'hAAAA_0000));
      tab.push_back(v(1, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h000, 0, 32'h0,        NOP));
      tab.push_back(v(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 10'h000, 0, 32'h0,        NOP));
      tab.push_back(v(1, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 10'h3FF, 0, 32'h0,        NOP));
      tab.push_back(v(1, 1, 0, 0, 0, 32'h0,        1, 1, 32'hDEAD_BEEF, 0, 10'h000, 0, 32'h0,        NOP));
      tab.push_back(v(1, 1, 0, 0, 0, 32'h0,        1, 1, 32'hAAAA_0001, 0, 10'h000, 1, 32'hFFFF_FFFC, 32'hAAAA_0001));

      foreach (tab[k]) apply(tab[k]);

      // Randomized traffic on instance 0. Reference: the IF/ID register must present
      // the program-order PC stream (start at 0, +4 each delivery, restart at the
      // redirect target), each carrying the word memory holds at that address.
      rv = '0; rdy = '0;
      exp_pc = 32'h0; cyc = 0; idle = 0; delivered = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         r_rst = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
         r_rdr = ($urandom_range(0, 99) < 4);
         r_fls = r_rdr && ($urandom_range(0, 1) == 1);
         r_stl = ($urandom_range(0, 3) == 0);
         r_rpc = $urandom;
         rst[0] = r_rst; rdr[0] = r_rdr; fls[0] = r_fls; stl[0] = r_stl; rpc[0] = r_rpc;
         rdy[0] = ($urandom_range(0, 3) != 0);
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv[0]   = 1'b1;
            rdat[0] = D + 32'(mq[0].a);
            void'(mq.pop_front());
         end else begin
            rv[0]   = 1'b0;
            rdat[0] = $urandom;
         end
         #1;
         acc = req[0] & rdy[0]; acc_a = addr[0];
         p_vld = vld[0]; p_ins = ins[0]; p_pc = pco[0]; p_pc4 = pc4[0];
         @(posedge clk);
         #1;
         cyc++;
         if (acc) mq.push_back('{a: acc_a, due: cyc + int'($urandom_range(0, 2))});
         idle++;
         if (!r_rst) begin
            chk("rnd_reset_valid", 32'(vld[0]), 32'd0);
            chk("rnd_reset_instr", ins[0], NOP);
            chk("rnd_reset_pc", pco[0], 32'd0);
            chk("rnd_reset_pc4", pc4[0], 32'd0);
            exp_pc = 32'h0;
         end else if (r_rdr || r_fls) begin
            chk("rnd_squash_valid", 32'(vld[0]), 32'd0);
            chk("rnd_squash_instr", ins[0], NOP);
            chk("rnd_squash_pc", pco[0], p_pc);
            if (r_rdr) exp_pc = r_rpc & ~32'd3;
         end else if (r_stl) begin
            chk("rnd_stall_valid", 32'(vld[0]), 32'(p_vld));
            chk("rnd_stall_instr", ins[0], p_ins);
            chk("rnd_stall_pc", pco[0], p_pc);
            chk("rnd_stall_pc4", pc4[0], p_pc4);
         end else if (vld[0]) begin
            chk("rnd_pc", pco[0], exp_pc);
            chk("rnd_instr", ins[0], D + 32'(exp_pc[11:2]));
            chk("rnd_pc4", pc4[0], exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
            idle = 0;
         end else begin
            chk("rnd_bubble_instr", ins[0], NOP);
         end
         if (idle == 150) begin
            checks++;
            failures++;
            $display("FAIL watchdog actual=%0d idle cycles required=<150", idle);
         end
      end
      chk("rnd_min_deliveries", 32'(delivered >= 200), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; directly upstream of the Decoder, which it feeds with instr, pc and pc+4.
- Holds the fetch PC and issues word requests to instruction memory over a req/ready handshake, with one outstanding request and variable response latency.
- Absorbs ID stalls in a one-entry hold buffer, and squashes on flush or branch/jump redirect from EX, including discarding an in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IMEM_AW, 10, instruction-memory word-address width.
- NOP_INSTR, 32'h0000_0013, instruction presented when IF/ID is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- stall  in  1  hazard stall from ID; hold IF/ID contents.
- flush  in  1  squash the IF/ID entry.
- redirect  in  1  branch taken / jal / jalr resolved in EX.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request valid.
- imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2].
- imem_ready  in  1  request accepted when imem_req & imem_ready.
- imem_rvalid  in  1  response valid; exactly one per accepted request, in order, at least 1 cycle after acceptance.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  IF/ID instruction.
- pc_out  out  32  PC of instr.
- pc_plus_4_out  out  32  pc_out+4.
- if_id_valid  out  1  IF/ID entry holds a real instruction.

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc=RESET_PC; state=FETCH; drop=0; hold buffer empty.
  - instr=NOP_INSTR, pc_out=0, pc_plus_4_out=0, if_id_valid=0.
  - imem_req is 0 during the reset cycle.
  - Reset mid-transaction: any later imem_rvalid belonging to a pre-reset request must be ignored. drop is set to 1 if state was WAIT at reset.
- FSM states:
  - FETCH: imem_req=1 (combinational on state). On imem_ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid with drop=1: clear drop, discard the data, stay in WAIT if another pre-reset request remains, else go to FETCH. On imem_rvalid with drop=0: deliver or buffer (see below), go to FETCH if delivered, HOLD if buffered.
  - HOLD: imem_req=0; the buffer holds {imem_rdata, req_pc}. Go to FETCH once the buffer is delivered to IF/ID.
- Redirect (highest priority after reset):
  - fetch_pc<=redirect_pc&~3.
  - In FETCH: the new address is presented next cycle. A request accepted in the same cycle is treated as stale: set drop, go to WAIT.
  - In WAIT: set drop (unless rvalid arrives the same cycle, in which case discard that data directly). Next request uses the new PC.
  - In HOLD: empty the buffer, go to FETCH.
- IF/ID register update, in priority order:
  - reset.
  - flush | redirect: if_id_valid<=0, instr<=NOP_INSTR; pc fields hold. Flush overrides stall.
  - stall: all IF/ID outputs hold. A response arriving now goes to the hold buffer.
  - HOLD with buffer full: load the buffer; if_id_valid<=1.
  - WAIT & imem_rvalid & !drop: load imem_rdata, req_pc, req_pc+4; if_id_valid<=1.
  - Otherwise: bubble (if_id_valid<=0, instr<=NOP_INSTR).
- Timing and arithmetic:
  - Throughput is at most 1 instruction per 2 cycles (single outstanding request).
  - With imem_ready=1 and 1-cycle response latency, a request in cycle n appears on IF/ID after the edge ending cycle n+1.
  - PC arithmetic is modulo 2^32: 0xFFFF_FFFC+4 wraps to 0, and pc_plus_4_out wraps likewise.
  - imem_addr truncates the upper PC bits.

Test Plan:
- Reset release, ready=1, 1-cycle memory holding word i = 0x1000_0000+i → IF/ID delivers valid entries pc_out=0,4,8 with instr 0x10000000, 0x10000001, 0x10000002, one valid entry every 2 cycles; imem_req=0 during reset.
- stall held for 4 cycles while the response for pc=8 arrives → outputs frozen at pc=4; after stall drops, pc=8 is delivered from HOLD the next cycle with no request reissued.
- redirect=1, redirect_pc=0x0000_0102 while in WAIT for pc=0x10 → that response is discarded, if_id_valid=0 for the cycle, next imem_addr=0x40, and the next delivered pc_out=0x100.
- flush and stall asserted together with a valid entry in IF/ID → if_id_valid=0 and instr=0x00000013 on the next cycle.
- imem_ready=0 for 5 cycles in FETCH → imem_req stays 1 and imem_addr stays stable; fetch_pc advances only on acceptance.
- RESET_PC=0xFFFF_FFFC → first entry has pc_plus_4_out=0 and the second fetch has imem_addr=0; a reset pulse during WAIT causes the stale rvalid to be ignored and fetch to restart at RESET_PC.
